// File: rtl/tetromino_queue.sv
// tetromino_queue: current tetromino plus a QUEUE_DEPTH-entry preview FIFO kept full by
// fetching from the tetromino BRAM (1-cycle read latency) at randomly generated addresses.
//
// Ports:
//   i_pixclk, i_reset_n            clock, synchronous active-low reset
//   i_start / i_clear / i_pop      begin filling / flush to idle / take next block
//   i_random_address               address from the random block generator
//   o_bram_addr0/ce0/we0/d0        BRAM port (registered address and enable, write tied off)
//   i_bram_q0                      BRAM read data, valid one cycle after ce
//   o_current_block/valid          active block
//   o_next_block                   FIFO head (0 when empty)
//   o_queue_count                  FIFO occupancy
//   o_ready                        pop may be accepted
//   o_addr_wrap                    pulses with ce when the address was folded into range
module tetromino_queue #(
    parameter int unsigned MEM_DWIDTH  = 32,
    parameter int unsigned MEM_AWIDTH  = 4,
    parameter int unsigned MEM_DEPTH   = 10,
    parameter int unsigned QUEUE_DEPTH = 3
) (
    input  logic                  i_pixclk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic                  i_clear,
    input  logic                  i_pop,
    input  logic [MEM_AWIDTH-1:0] i_random_address,
    output logic [MEM_AWIDTH-1:0] o_bram_addr0,
    output logic                  o_bram_ce0,
    output logic                  o_bram_we0,
    output logic [MEM_DWIDTH-1:0] o_bram_d0,
    input  logic [MEM_DWIDTH-1:0] i_bram_q0,
    output logic [MEM_DWIDTH-1:0] o_current_block,
    output logic                  o_current_valid,
    output logic [MEM_DWIDTH-1:0] o_next_block,
    output logic [3:0]            o_queue_count,
    output logic                  o_ready,
    output logic                  o_addr_wrap
);

    localparam logic [MEM_AWIDTH:0] MemDepthExt = (MEM_AWIDTH+1)'(MEM_DEPTH);
    localparam logic [4:0]          QDepthExt   = 5'(QUEUE_DEPTH);
    localparam logic [3:0]          QDepthCnt   = 4'(QUEUE_DEPTH);

    typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

    state_e                r_state;
    state_e                w_state_nxt;

    logic [3:0]            r_count;
    logic                  r_ce;
    logic                  r_pend;   // read issued last cycle, data arrives on i_bram_q0 now
    logic [MEM_AWIDTH-1:0] r_addr;
    logic                  r_wrap;
    logic [MEM_DWIDTH-1:0] r_cur;
    logic                  r_cur_valid;
    logic [MEM_DWIDTH-1:0] r_fifo     [QUEUE_DEPTH];
    logic [MEM_DWIDTH-1:0] w_fifo_nxt [QUEUE_DEPTH];

    logic                  w_fetch_active;
    logic                  w_in_fill;
    logic                  w_in_run;
    logic                  w_ready;
    logic                  w_autoload;
    logic                  w_pop;
    logic                  w_shift;
    logic                  w_issue;
    logic [1:0]            w_outstanding;
    logic [4:0]            w_proj;
    logic [3:0]            w_wr_pos;
    logic                  w_fold_hit;
    logic [MEM_AWIDTH-1:0] w_fold_addr;

    // State register
    always_ff @(posedge i_pixclk) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = StIdle;
        end else begin
            unique case (r_state)
                StIdle:  if (i_start) w_state_nxt = StFill;
                StFill:  if (w_autoload) w_state_nxt = StRun;
                StRun:   w_state_nxt = StRun;
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    // State decode
    always_comb begin
        w_fetch_active = 1'b0;
        w_in_fill      = 1'b0;
        w_in_run       = 1'b0;
        unique case (r_state)
            StIdle: w_fetch_active = i_start;
            StFill: begin
                w_fetch_active = 1'b1;
                w_in_fill      = 1'b1;
            end
            StRun: begin
                w_fetch_active = 1'b1;
                w_in_run       = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_outstanding = {1'b0, r_ce} + {1'b0, r_pend};
    assign w_ready       = r_cur_valid && (r_count == QDepthCnt) && (w_outstanding == 2'd0);
    assign w_autoload    = w_in_fill && (r_count == QDepthCnt) && !r_cur_valid;
    assign w_pop         = w_in_run && i_pop && w_ready;
    assign w_shift       = w_autoload || w_pop;

    // Projected occupancy once every in-flight read lands; a shift only happens at a full FIFO,
    // so the subtraction cannot underflow.
    assign w_proj  = {1'b0, r_count} + {3'b000, w_outstanding} - {4'b0000, w_shift};
    assign w_issue = w_fetch_active && (w_proj < QDepthExt);

    assign w_fold_hit  = {1'b0, i_random_address} >= MemDepthExt;
    assign w_fold_addr = w_fold_hit ? (i_random_address - MemDepthExt[MEM_AWIDTH-1:0])
                                    : i_random_address;

    // Returning data goes behind whatever remains after this edge's shift.
    assign w_wr_pos = r_count - {3'b000, w_shift};

    always_comb begin
        for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
            w_fifo_nxt[i] = r_fifo[i];
        end
        if (w_shift) begin
            for (int i = 0; i < int'(QUEUE_DEPTH) - 1; i++) begin
                w_fifo_nxt[i] = r_fifo[i+1];
            end
        end
        if (r_pend) begin
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                if (w_wr_pos == 4'(i)) w_fifo_nxt[i] = i_bram_q0;
            end
        end
    end

    always_ff @(posedge i_pixclk) begin
        if (!i_reset_n) begin
            r_count     <= '0;
            r_ce        <= 1'b0;
            r_pend      <= 1'b0;
            r_addr      <= '0;
            r_wrap      <= 1'b0;
            r_cur       <= '0;
            r_cur_valid <= 1'b0;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                r_fifo[i] <= '0;
            end
        end else if (i_clear) begin
            // Dropping r_pend discards any read data still on its way back.
            r_count     <= '0;
            r_ce        <= 1'b0;
            r_pend      <= 1'b0;
            r_wrap      <= 1'b0;
            r_cur       <= '0;
            r_cur_valid <= 1'b0;
        end else begin
            r_count <= r_count + {3'b000, r_pend} - {3'b000, w_shift};
            r_pend  <= r_ce;
            r_ce    <= w_issue;
            r_wrap  <= w_issue && w_fold_hit;
            if (w_issue) r_addr <= w_fold_addr;
            if (w_shift) begin
                r_cur       <= r_fifo[0];
                r_cur_valid <= 1'b1;
            end
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                r_fifo[i] <= w_fifo_nxt[i];
            end
        end
    end

    assign o_bram_addr0    = r_addr;
    assign o_bram_ce0      = r_ce;
    assign o_bram_we0      = 1'b0;
    assign o_bram_d0       = '0;
    assign o_current_block = r_cur;
    assign o_current_valid = r_cur_valid;
    assign o_next_block    = (r_count != 4'd0) ? r_fifo[0] : '0;
    assign o_queue_count   = r_count;
    assign o_ready         = w_ready;
    assign o_addr_wrap     = r_wrap;

endmodule

// File: tb/tb_tetromino_queue.sv
module tb_tetromino_queue;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned MD = 10;
    localparam int unsigned QD = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          clear;
    logic          pop;
    logic [AW-1:0] raddr;
    logic [AW-1:0] bram_addr;
    logic          bram_ce;
    logic          bram_we;
    logic [DW-1:0] bram_d;
    logic [DW-1:0] bram_q = '0;
    logic [DW-1:0] cur_block;
    logic          cur_valid;
    logic [DW-1:0] next_block;
    logic [3:0]    q_count;
    logic          ready;
    logic          addr_wrap;

    always #5 clk = ~clk;

    tetromino_queue #(
        .MEM_DWIDTH (DW),
        .MEM_AWIDTH (AW),
        .MEM_DEPTH  (MD),
        .QUEUE_DEPTH(QD)
    ) dut (
        .i_pixclk        (clk),
        .i_reset_n       (rst_n),
        .i_start         (start),
        .i_clear         (clear),
        .i_pop           (pop),
        .i_random_address(raddr),
        .o_bram_addr0    (bram_addr),
        .o_bram_ce0      (bram_ce),
        .o_bram_we0      (bram_we),
        .o_bram_d0       (bram_d),
        .i_bram_q0       (bram_q),
        .o_current_block (cur_block),
        .o_current_valid (cur_valid),
        .o_next_block    (next_block),
        .o_queue_count   (q_count),
        .o_ready         (ready),
        .o_addr_wrap     (addr_wrap)
    );

    // Tetromino BRAM: synchronous read, one cycle latency.
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (bram_ce) bram_q <= mem[bram_addr];
    end

    // Reference model: preview FIFO as a queue, in-flight reads as (due cycle, data) pairs.
    int            cyc = 0;
    int            m_state = 0;  // 0 idle, 1 filling, 2 running
    logic [DW-1:0] m_fifo[$];
    int            m_due[$];
    logic [DW-1:0] m_data[$];
    logic [DW-1:0] m_cur = '0;
    logic          m_cur_valid = 1'b0;
    logic          m_ce = 1'b0;
    logic          m_wrap = 1'b0;
    logic [AW-1:0] m_addr = '0;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge();
        int cnt;
        int out;
        int a;
        bit rdy, fetching, autoload, take, shift, issue, write;
        cnt = m_fifo.size();
        out = m_due.size();
        if (!rst_n) begin
            m_state = 0;
            m_fifo.delete();
            m_due.delete();
            m_data.delete();
            m_cur = '0;
            m_cur_valid = 1'b0;
            m_ce = 1'b0;
            m_wrap = 1'b0;
            m_addr = '0;
        end else if (clear) begin
            m_state = 0;
            m_fifo.delete();
            m_due.delete();
            m_data.delete();
            m_cur = '0;
            m_cur_valid = 1'b0;
            m_ce = 1'b0;
            m_wrap = 1'b0;
        end else begin
            rdy      = m_cur_valid && cnt == int'(QD) && out == 0;
            fetching = (m_state == 0 && start) || m_state != 0;
            autoload = m_state == 1 && cnt == int'(QD) && !m_cur_valid;
            take     = m_state == 2 && pop && rdy;
            shift    = autoload || take;
            write    = out > 0 && m_due[0] == cyc;
            issue    = fetching && (cnt - int'(shift) + out < int'(QD));
            if (shift) begin
                m_cur = m_fifo.pop_front();
                m_cur_valid = 1'b1;
            end
            if (write) begin
                m_fifo.push_back(m_data.pop_front());
                m_due.delete(0);
            end
            m_ce = issue;
            m_wrap = 1'b0;
            if (issue) begin
                a = int'(raddr);
                if (a >= int'(MD)) begin
                    a = a - int'(MD);
                    m_wrap = 1'b1;
                end
                m_addr = AW'(a);
                m_due.push_back(cyc + 2);
                m_data.push_back(mem[a]);
            end
            if (m_state == 0 && start) m_state = 1;
            else if (m_state == 1 && autoload) m_state = 2;
        end
        cyc++;
    endtask

    task automatic check_all();
        logic [DW-1:0] exp_next;
        logic          exp_ready;
        exp_next  = (m_fifo.size() != 0) ? m_fifo[0] : '0;
        exp_ready = m_cur_valid && m_fifo.size() == int'(QD) && m_due.size() == 0;
        check("ce", 64'(bram_ce), 64'(m_ce));
        if (m_ce) check("addr", 64'(bram_addr), 64'(m_addr));
        check("wrap", 64'(addr_wrap), 64'(m_wrap));
        check("we", 64'(bram_we), 64'(0));
        check("d0", 64'(bram_d), 64'(0));
        check("cur", 64'(cur_block), 64'(m_cur));
        check("cur_valid", 64'(cur_valid), 64'(m_cur_valid));
        check("next", 64'(next_block), 64'(exp_next));
        check("count", 64'(q_count), 64'(m_fifo.size()));
        check("ready", 64'(ready), 64'(exp_ready));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hA0 + 32'(i);
        rst_n = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        pop   = 1'b0;
        raddr = '0;
        step();
        step();
        check("rst_addr", 64'(bram_addr), 64'(0));
        check("rst_cur", 64'(cur_block), 64'(0));
        rst_n = 1'b1;
        step();

        // Reset in the middle of filling; the stale read must not land.
        start = 1'b1; raddr = 4'd3;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_ce", 64'(bram_ce), 64'(0));
        step();
        check("midrst_count", 64'(q_count), 64'(0));
        step();

        // Fill sequence from idle.
        start = 1'b1; raddr = 4'd2;
        step();                                  // edge 0
        start = 1'b0; raddr = 4'd5;
        step();                                  // edge 1
        raddr = 4'd7;
        step();                                  // edge 2
        raddr = 4'd1;
        step();                                  // edge 3
        step();                                  // edge 4
        step();                                  // edge 5
        check("fill_cur", 64'(cur_block), 64'(32'hA2));
        check("fill_next", 64'(next_block), 64'(32'hA5));
        step();                                  // edge 6
        check("fill_ready6", 64'(ready), 64'(0));
        step();                                  // edge 7
        check("fill_ready7", 64'(ready), 64'(1));
        check("fill_count", 64'(q_count), 64'(3));

        // Pops, including a folded address.
        pop = 1'b1; raddr = 4'd4;
        step();
        pop = 1'b0;
        check("pop_cur", 64'(cur_block), 64'(32'hA5));
        check("pop_next", 64'(next_block), 64'(32'hA7));
        check("pop_ce", 64'(bram_ce), 64'(1));
        check("pop_addr", 64'(bram_addr), 64'(4));
        step();
        check("pop_ce_off", 64'(bram_ce), 64'(0));
        step();
        check("pop_ready", 64'(ready), 64'(1));
        pop = 1'b1; raddr = 4'd0;
        step();
        pop = 1'b0;
        step();
        step();
        pop = 1'b1; raddr = 4'd12;
        step();
        pop = 1'b0;
        check("tail_cur", 64'(cur_block), 64'(32'hA1));
        check("tail_next", 64'(next_block), 64'(32'hA4));
        check("wrap_addr", 64'(bram_addr), 64'(2));
        check("wrap_pulse", 64'(addr_wrap), 64'(1));
        step();
        check("wrap_gone", 64'(addr_wrap), 64'(0));
        step();

        // Pop held for three edges: only the first is taken.
        pop = 1'b1; raddr = 4'd6;
        step();
        check("hold_count1", 64'(q_count), 64'(2));
        step();
        step();
        pop = 1'b0;
        check("hold_count3", 64'(q_count), 64'(3));
        check("hold_cur", 64'(cur_block), 64'(32'hA4));
        step();

        // Clear right after a pop's read was issued, then refill.
        pop = 1'b1; raddr = 4'd5;
        step();
        pop = 1'b0; clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_count", 64'(q_count), 64'(0));
        check("clr_cur", 64'(cur_block), 64'(0));
        check("clr_next", 64'(next_block), 64'(0));
        step();
        check("clr_stale", 64'(q_count), 64'(0));
        start = 1'b1; raddr = 4'd3;
        step();                                  // edge 0
        start = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            raddr = AW'($urandom_range(0, 15));
            step();
        end
        check("refill_ready6", 64'(ready), 64'(0));
        step();                                  // edge 7
        check("refill_ready7", 64'(ready), 64'(1));

        // Randomized phase against the model.
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            clear = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 7) == 0);
            pop   = 1'($urandom_range(0, 1));
            raddr = AW'($urandom_range(0, 15));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/tetromino_queue.md
Name: tetromino_queue

Overview:
- Parametrised successor to the game FSM's lobby/new-block fetch logic.
- Holds a current tetromino plus a QUEUE_DEPTH-entry preview FIFO, and keeps the FIFO full by fetching from the tetromino BRAM (1-cycle read latency) at addresses from the random block address generator.
- The game FSM pulses i_pop on entering its new-block state and reads o_current_block and o_next_block.

Parameters:
- MEM_DWIDTH, 32, tetromino word width (shape plus colour).
- MEM_AWIDTH, 4, BRAM address width.
- MEM_DEPTH, 10, number of valid BRAM entries. Requires MEM_DEPTH <= 2^MEM_AWIDTH <= 2*MEM_DEPTH.
- QUEUE_DEPTH, 3, preview FIFO entries. Legal range 1..8.

Ports:
- i_pixclk  in  1  clock.
- i_reset_n  in  1  reset, synchronous, active-low.
- i_start  in  1  begin filling. Honoured only in ST_IDLE.
- i_clear  in  1  flush queue and return to ST_IDLE (lobby/game over).
- i_pop  in  1  request next block. Accepted only when o_ready=1.
- i_random_address  in  MEM_AWIDTH  address from the generator.
- o_bram_addr0  out  MEM_AWIDTH  BRAM address (registered).
- o_bram_ce0  out  1  BRAM read enable (registered).
- o_bram_we0  out  1  tied 0.
- o_bram_d0  out  MEM_DWIDTH  tied 0.
- i_bram_q0  in  MEM_DWIDTH  BRAM read data, valid 1 cycle after ce.
- o_current_block  out  MEM_DWIDTH  active block.
- o_current_valid  out  1  o_current_block holds a fetched block.
- o_next_block  out  MEM_DWIDTH  FIFO head, or 0 when the FIFO is empty.
- o_queue_count  out  4  FIFO occupancy, 0..QUEUE_DEPTH.
- o_ready  out  1  o_current_valid and count==QUEUE_DEPTH and no fetch outstanding.
- o_addr_wrap  out  1  1-cycle pulse when an out-of-range address was folded.

Behaviour:
- Reset: state ST_IDLE. All outputs, FIFO contents, outstanding count and current register are 0.
- Priority per edge: reset > i_clear > i_start/i_pop/fetch activity.
- States:
  - ST_IDLE: no fetches. i_start moves to ST_FILL on that edge and issues the first fetch on the same edge.
  - ST_FILL: fetching and auto-load; i_pop is ignored. Moves to ST_RUN on the edge that auto-load occurs.
  - ST_RUN: steady state; i_pop is honoured.
- Outstanding fetch count: 0..2, covering ce-issued plus data-pending.
- Fetch issue (ST_FILL/ST_RUN, or the accepting i_start edge): issue when (count - pop_now + outstanding) < QUEUE_DEPTH.
  - On issue: o_bram_ce0<=1 and o_bram_addr0<=folded address for the next cycle; otherwise o_bram_ce0<=0.
  - Back-to-back issues are allowed.
- Address fold: if i_random_address >= MEM_DEPTH, use i_random_address - MEM_DEPTH and pulse o_addr_wrap in the same cycle as ce.
- Write: i_bram_q0 is pushed to the FIFO tail on the edge 2 after the issue edge. Order equals issue order.
- Auto-load (ST_FILL): on the edge where count==QUEUE_DEPTH and o_current_valid==0:
  - current<=head, the FIFO shifts, o_current_valid<=1;
  - a refill issues on the same edge.
- Pop accepted at edge k:
  - current<=head and the FIFO shifts after edge k;
  - o_bram_ce0 is high for cycle k..k+1;
  - the refill is written at edge k+2, and o_ready is high after edge k+2.
- Pop when o_ready=0 is ignored, with no state change.
- Simultaneous pop and write on the same edge: shift and push occur together; count unchanged.
- Fill latency: with i_start at edge 0, fetches issue at edges 0..QUEUE_DEPTH-1, count reaches QUEUE_DEPTH after edge QUEUE_DEPTH+1, auto-load occurs at edge QUEUE_DEPTH+2, and o_ready=1 after edge QUEUE_DEPTH+4.
- i_clear, including mid-fetch:
  - state<=ST_IDLE; count, outstanding, o_current_valid, o_bram_ce0 <=0;
  - o_current_block and o_next_block read 0;
  - any BRAM data returning next cycle is discarded.
- i_start outside ST_IDLE is ignored. i_start and i_clear on the same edge: clear wins.
- Count never exceeds QUEUE_DEPTH and never underflows; the issue rule guarantees this.

Test Plan:
- Reset mid-ST_FILL (QUEUE_DEPTH=3) -> all outputs 0 the cycle after; a stale q return is not written.
- Fill: QUEUE_DEPTH=3; i_start at edge 0; addresses 2,5,7 then 1; BRAM word = 0xA0+addr -> current=0xA2 after edge 5, next=0xA5, o_ready=1 after edge 7, count=3.
- Pop in ST_RUN at edge k, next address 4 -> current=0xA5 after k, next=0xA7, ce high exactly one cycle with addr 4, o_ready=1 after k+2, FIFO tail=0xA4.
- Pop held high for 3 cycles -> exactly one pop accepted per o_ready window; no count underflow.
- i_random_address=12, MEM_DEPTH=10 -> o_bram_addr0=2, o_addr_wrap pulses for 1 cycle.
- i_clear asserted the cycle after a pop's ce -> ST_IDLE, count=0, returned data ignored; then i_start refills normally, with o_ready=1 after edge 7 relative to i_start.
